uart_cmd_rx: RTL and testbench

//   UART receive path and command decoder: the host-to-board counterpart of the distance

---
 rtl/uart_cmd_rx_if.sv | 32 +++
 rtl/uart_cmd_rx.sv | 261 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_rx_if
// Description : Bundle of the UART command receiver's line input, byte
//               strobes and decoded command outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_rx_if;
    logic        rx_data;
    logic [7:0]  rx_byte;
    logic        rx_byte_vld;
    logic        frame_err;
    logic        beep_en;
    logic [15:0] thresh_cm;
    logic        cmd_vld;
    logic        cmd_err;

    // Receiver side: samples the line, produces bytes and commands
    modport master (
        input  rx_data,
        output rx_byte, rx_byte_vld, frame_err,
        output beep_en, thresh_cm, cmd_vld, cmd_err
    );

    // Host/consumer side: drives the line, observes results
    modport slave (
        output rx_data,
        input  rx_byte, rx_byte_vld, frame_err,
        input  beep_en, thresh_cm, cmd_vld, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_rx
// Description : 8N1 UART receiver plus 5-byte command packet parser
//               (0xA5, CMD, D1, D0, CMD^D1^D0) driving beeper enable and
//               alarm threshold.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_rx #(
    parameter int          CLK_FREQ       = 50_000_000,
    parameter int          BAUD           = 115200,
    parameter logic [15:0] THRESH_DEFAULT = 16'd30,
    parameter int          TIMEOUT_CYC    = 500_000
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_cmd_rx_if.master bus
);
    localparam int c_BAUD_DIV = CLK_FREQ / BAUD;
    localparam int c_HALF_DIV = c_BAUD_DIV / 2;
    localparam int c_BAUD_W   = $clog2(c_BAUD_DIV);
    localparam int c_IDLE_W   = $clog2(TIMEOUT_CYC);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_BAUD_DIV - 1);
    localparam logic [c_BAUD_W-1:0] c_HALF_LAST = c_BAUD_W'(c_HALF_DIV - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYC - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_ONE  = c_IDLE_W'(1);

    localparam logic [7:0] c_HEAD      = 8'hA5;
    localparam logic [7:0] c_OP_THRESH = 8'h01;
    localparam logic [7:0] c_OP_BEEP   = 8'h02;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        P_HEAD = 3'd0,
        P_CMD  = 3'd1,
        P_D1   = 3'd2,
        P_D0   = 3'd3,
        P_SUM  = 3'd4
    } p_state_t;

    // ------------------------------------------------------------------
    // Line synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic r_sync1, r_sync2, r_sync_d;
    logic w_rx, w_fall;

    // Two-flop synchroniser plus one delay flop for edge detection; idle high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_sync_d <= 1'b1;
        end else begin
            r_sync1  <= bus.rx_data;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = r_sync_d & ~r_sync2;

    // ------------------------------------------------------------------
    // Byte receiver
    // ------------------------------------------------------------------
    rx_state_t           r_rx_state, w_rx_next;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_rx_byte;
    logic                r_rx_byte_vld;
    logic                r_frame_err;
    logic                w_baud_clr, w_bit_take, w_byte_ok, w_stop_bad;

    // Byte FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    // Byte FSM next state and sample strobes
    always_comb begin
        w_rx_next  = r_rx_state;
        w_baud_clr = 1'b0;
        w_bit_take = 1'b0;
        w_byte_ok  = 1'b0;
        w_stop_bad = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_baud_clr = 1'b1;
                    w_rx_next  = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit check rejects short low glitches
                if (r_baud_cnt == c_HALF_LAST) begin
                    w_baud_clr = 1'b1;
                    w_rx_next  = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_baud_cnt == c_BAUD_LAST) begin
                    w_baud_clr = 1'b1;
                    w_bit_take = 1'b1;
                    if (r_bit_cnt == 3'd7) w_rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_baud_cnt == c_BAUD_LAST) begin
                    w_baud_clr = 1'b1;
                    w_rx_next  = RX_IDLE;
                    w_byte_ok  = w_rx;
                    w_stop_bad = ~w_rx;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // Baud and bit counters, data shift register, byte output strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt    <= '0;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'h00;
            r_rx_byte     <= 8'h00;
            r_rx_byte_vld <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_baud_clr || r_rx_state == RX_IDLE)
                r_baud_cnt <= '0;
            else if (r_baud_cnt != c_BAUD_LAST)
                r_baud_cnt <= r_baud_cnt + c_BAUD_ONE;

            if (r_rx_state != RX_DATA)
                r_bit_cnt <= 3'd0;
            else if (w_bit_take && r_bit_cnt != 3'd7)
                r_bit_cnt <= r_bit_cnt + 3'd1;

            // LSB arrives first, so shift in from the top
            if (w_bit_take)
                r_shift <= {w_rx, r_shift[7:1]};

            if (w_byte_ok)
                r_rx_byte <= r_shift;
            r_rx_byte_vld <= w_byte_ok;
            r_frame_err   <= w_stop_bad;
        end
    end

    // ------------------------------------------------------------------
    // Packet parser
    // ------------------------------------------------------------------
    p_state_t            r_p_state, w_p_next;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [7:0]          r_cmd, r_d1, r_d0;
    logic [15:0]         r_thresh;
    logic                r_beep;
    logic                r_cmd_vld, r_cmd_err;
    logic                w_timeout, w_sum_ok;
    logic                w_cap_cmd, w_cap_d1, w_cap_d0;
    logic                w_set_thresh, w_set_beep, w_reject;

    assign w_timeout = (r_idle_cnt == c_IDLE_LAST) && !r_rx_byte_vld;
    assign w_sum_ok  = (r_rx_byte == (r_cmd ^ r_d1 ^ r_d0));

    // Parser FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_p_state <= P_HEAD;
        else        r_p_state <= w_p_next;
    end

    // Parser FSM next state; aborts take priority over byte handling
    always_comb begin
        w_p_next     = r_p_state;
        w_cap_cmd    = 1'b0;
        w_cap_d1     = 1'b0;
        w_cap_d0     = 1'b0;
        w_set_thresh = 1'b0;
        w_set_beep   = 1'b0;
        w_reject     = 1'b0;
        if (r_p_state != P_HEAD && (r_frame_err || w_timeout)) begin
            w_p_next = P_HEAD;
            w_reject = 1'b1;
        end else if (r_rx_byte_vld) begin
            case (r_p_state)
                P_HEAD: if (r_rx_byte == c_HEAD) w_p_next = P_CMD;
                P_CMD: begin
                    w_cap_cmd = 1'b1;
                    w_p_next  = P_D1;
                end
                P_D1: begin
                    w_cap_d1 = 1'b1;
                    w_p_next = P_D0;
                end
                P_D0: begin
                    w_cap_d0 = 1'b1;
                    w_p_next = P_SUM;
                end
                P_SUM: begin
                    w_p_next = P_HEAD;
                    if (w_sum_ok && r_cmd == c_OP_THRESH)
                        w_set_thresh = 1'b1;
                    else if (w_sum_ok && r_cmd == c_OP_BEEP)
                        w_set_beep = 1'b1;
                    else
                        w_reject = 1'b1;
                end
                default: w_p_next = P_HEAD;
            endcase
        end
    end

    // Inter-byte idle counter, packet field capture and command outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
            r_cmd      <= 8'h00;
            r_d1       <= 8'h00;
            r_d0       <= 8'h00;
            r_thresh   <= THRESH_DEFAULT;
            r_beep     <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            if (r_rx_byte_vld || r_p_state == P_HEAD)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != c_IDLE_LAST)
                r_idle_cnt <= r_idle_cnt + c_IDLE_ONE;

            if (w_cap_cmd) r_cmd <= r_rx_byte;
            if (w_cap_d1)  r_d1  <= r_rx_byte;
            if (w_cap_d0)  r_d0  <= r_rx_byte;

            if (w_set_thresh) r_thresh <= {r_d1, r_d0};
            if (w_set_beep)   r_beep   <= r_d0[0];

            r_cmd_vld <= w_set_thresh | w_set_beep;
            r_cmd_err <= w_reject;
        end
    end

    assign bus.rx_byte     = r_rx_byte;
    assign bus.rx_byte_vld = r_rx_byte_vld;
    assign bus.frame_err   = r_frame_err;
    assign bus.beep_en     = r_beep;
    assign bus.thresh_cm   = r_thresh;
    assign bus.cmd_vld     = r_cmd_vld;
    assign bus.cmd_err     = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_rx
// Description : Directed self-checking bench for uart_cmd_rx, run at a
//               reduced clock so one bit lasts 16 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_rx;
    localparam int c_CLK_FREQ = 1_843_200;
    localparam int c_BAUD     = 115200;
    localparam int c_DIV      = c_CLK_FREQ / c_BAUD;   // 16
    localparam int c_TIMEOUT  = 2000;

    logic clk = 1'b0;
    logic rst_n;

    uart_cmd_rx_if bus ();

    uart_cmd_rx #(
        .CLK_FREQ       (c_CLK_FREQ),
        .BAUD           (c_BAUD),
        .THRESH_DEFAULT (16'd30),
        .TIMEOUT_CYC    (c_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Event monitor, sampled on the falling edge
    int         cyc = 0;
    int         n_vld = 0, n_ferr = 0, n_cvld = 0, n_cerr = 0, n_both = 0;
    int         vld_cyc = 0, ferr_cyc = 0, cvld_cyc = 0, cerr_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic [15:0] cvld_thresh = 16'h0;

    always @(negedge clk) begin
        if (bus.rx_byte_vld) begin n_vld++; vld_cyc = cyc; last_byte = bus.rx_byte; end
        if (bus.frame_err)   begin n_ferr++; ferr_cyc = cyc; end
        if (bus.cmd_vld)     begin n_cvld++; cvld_cyc = cyc; cvld_thresh = bus.thresh_cm; end
        if (bus.cmd_err)     begin n_cerr++; cerr_cyc = cyc; end
        if (bus.cmd_vld && bus.cmd_err) n_both++;
        cyc = cyc + 1;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        bus.rx_data = v;
        repeat (c_DIV) @(posedge clk);
        #1;
    endtask

    // Start, 8 data LSB first, stop, then one idle bit
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        send_bit(1'b1);
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] d1,
                            input logic [7:0] d0, input logic [7:0] s);
        send_byte(8'hA5, 1'b1);
        send_byte(c, 1'b1);
        send_byte(d1, 1'b1);
        send_byte(d0, 1'b1);
        send_byte(s, 1'b1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_vld, b_ferr, b_cvld, b_cerr, lat;
        rst_n       = 1'b0;
        bus.rx_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_byte",  32'(bus.rx_byte), 32'h00);
        check("rst_vld",      32'(bus.rx_byte_vld), 32'd0);
        check("rst_ferr",     32'(bus.frame_err), 32'd0);
        check("rst_beep",     32'(bus.beep_en), 32'd0);
        check("rst_thresh",   32'(bus.thresh_cm), 32'd30);
        check("rst_cmd_vld",  32'(bus.cmd_vld), 32'd0);
        check("rst_cmd_err",  32'(bus.cmd_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single byte while parser waits for a header: no command effect
        b_vld = n_vld; b_ferr = n_ferr; b_cerr = n_cerr;
        send_byte(8'h3C, 1'b1);
        check("t1_vld_count", 32'(n_vld - b_vld), 32'd1);
        check("t1_rx_byte",   32'(last_byte), 32'h3C);
        check("t1_no_ferr",   32'(n_ferr - b_ferr), 32'd0);
        check("t1_no_cerr",   32'(n_cerr - b_cerr), 32'd0);

        // Threshold command
        b_cvld = n_cvld;
        send_pkt(8'h01, 8'h00, 8'h64, 8'h65);
        check("t2_thresh",     32'(bus.thresh_cm), 32'd100);
        check("t2_cvld_count", 32'(n_cvld - b_cvld), 32'd1);
        check("t2_latency",    32'(cvld_cyc - vld_cyc), 32'd1);
        check("t2_same_cycle", 32'(cvld_thresh), 32'd100);

        // Beeper on then off
        b_cvld = n_cvld;
        send_pkt(8'h02, 8'h00, 8'h01, 8'h03);
        check("t3_beep_on", 32'(bus.beep_en), 32'd1);
        send_pkt(8'h02, 8'h00, 8'h00, 8'h02);
        check("t3_beep_off",   32'(bus.beep_en), 32'd0);
        check("t3_cvld_count", 32'(n_cvld - b_cvld), 32'd2);

        // Bad checksum and bad opcode
        b_cvld = n_cvld; b_cerr = n_cerr;
        send_pkt(8'h01, 8'h00, 8'h64, 8'h66);
        check("t4_sum_cerr",   32'(n_cerr - b_cerr), 32'd1);
        check("t4_sum_lat",    32'(cerr_cyc - vld_cyc), 32'd1);
        check("t4_thresh",     32'(bus.thresh_cm), 32'd100);
        send_pkt(8'h07, 8'h00, 8'h00, 8'h07);
        check("t4_op_cerr",    32'(n_cerr - b_cerr), 32'd2);
        check("t4_no_cvld",    32'(n_cvld - b_cvld), 32'd0);
        check("t4_beep_held",  32'(bus.beep_en), 32'd0);

        // Inter-byte timeout, then a clean packet
        b_cerr = n_cerr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        lat = 0;
        repeat (c_TIMEOUT + 400) @(posedge clk);
        #1;
        lat = cerr_cyc - vld_cyc;
        check("t5_to_cerr", 32'(n_cerr - b_cerr), 32'd1);
        check("t5_to_lat",  32'(lat >= c_TIMEOUT && lat <= c_TIMEOUT + 2), 32'd1);
        send_pkt(8'h01, 8'h01, 8'h2C, 8'h2C);
        check("t5_thresh", 32'(bus.thresh_cm), 32'd300);

        // Frame error mid-packet
        b_ferr = n_ferr; b_cerr = n_cerr;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("t6_ferr",       32'(n_ferr - b_ferr), 32'd1);
        check("t6_cerr",       32'(n_cerr - b_cerr), 32'd1);
        check("t6_cerr_lat",   32'(cerr_cyc - ferr_cyc), 32'd1);
        check("t6_thresh",     32'(bus.thresh_cm), 32'd300);

        // Header value inside a packet is ordinary data
        send_pkt(8'h01, 8'hA5, 8'h00, 8'hA4);
        check("t6_a5_data", 32'(bus.thresh_cm), 32'hA500);

        // Frame error while idle: no packet error
        b_ferr = n_ferr; b_cerr = n_cerr;
        send_byte(8'h00, 1'b0);
        check("t6_head_ferr", 32'(n_ferr - b_ferr), 32'd1);
        check("t6_head_cerr", 32'(n_cerr - b_cerr), 32'd0);

        // Short low glitch produces nothing
        b_vld = n_vld; b_ferr = n_ferr;
        bus.rx_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.rx_data = 1'b1;
        repeat (20 * c_DIV) @(posedge clk);
        #1;
        check("t6_glitch_vld",  32'(n_vld - b_vld), 32'd0);
        check("t6_glitch_ferr", 32'(n_ferr - b_ferr), 32'd0);

        // Only D0[0] controls the beeper
        send_pkt(8'h02, 8'hFF, 8'hFF, 8'h02);
        check("t6_beep_d0", 32'(bus.beep_en), 32'd1);
        check("t6_thr_kept", 32'(bus.thresh_cm), 32'hA500);

        // Asynchronous reset part way through a byte
        b_vld = n_vld;
        bus.rx_data = 1'b0;
        repeat (5 * c_DIV) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_thresh", 32'(bus.thresh_cm), 32'd30);
        check("t6_rst_beep",   32'(bus.beep_en), 32'd0);
        bus.rx_data = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20 * c_DIV) @(posedge clk);
        #1;
        check("t6_rst_no_byte", 32'(n_vld - b_vld), 32'd0);
        send_pkt(8'h01, 8'h00, 8'h64, 8'h65);
        check("t6_recover", 32'(bus.thresh_cm), 32'd100);

        check("never_both", 32'(n_both), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
